// File: rtl/fcmp_pkg.sv
// fcmp_pkg: shared opcodes, FSM states and IEEE-754 constants for the fcmp controller
package fcmp_pkg;
  typedef enum logic [2:0] {
    OP_MIN = 3'd0,
    OP_MAX = 3'd1,
    OP_EQ  = 3'd2,
    OP_LT  = 3'd3,
    OP_LE  = 3'd4
  } fcmp_op_e;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fcmp_state_e;
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  localparam logic [31:0] NEG_ZERO  = 32'h80000000;
  localparam logic [7:0]  EXP_ALL1  = 8'hFF;
endpackage

// File: rtl/fcmp_ctrl_if.sv
// fcmp_ctrl_if: request/response handshake bundle between FPU issue, fcmp_ctrl and writeback
//   req_*: valid/ready request carrying op, operands a/b and tag
//   rsp_*: valid/ready response carrying result, invalid flag and tag
interface fcmp_ctrl_if #(parameter int TAG_W = 4);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic             rsp_nv;
  logic [TAG_W-1:0] rsp_tag;
  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_nv, rsp_tag
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_nv, rsp_tag
  );
endinterface

// File: rtl/fcmp.sv
// fcmp: single-precision comparator core, valid for non-NaN operands, LATENCY register stages
//   clk_i: clock; operand_a/operand_b: inputs
//   min/max/equal/less/less_equal: comparison results, LATENCY cycles after operands
module fcmp #(parameter int LATENCY = 1) (
  input  logic        clk_i,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] min,
  output logic [31:0] max,
  output logic        equal,
  output logic        less,
  output logic        less_equal
);
  logic        both_zero, eq, lt;
  logic [66:0] vec, out;
  assign both_zero = ~|{operand_a[30:0], operand_b[30:0]};
  assign eq = (operand_a == operand_b) || both_zero;
  // sign-magnitude order: negative magnitudes compare reversed
  assign lt = (operand_a[31] != operand_b[31]) ? (operand_a[31] && !both_zero)
            : operand_a[31] ? (operand_a[30:0] > operand_b[30:0])
            : (operand_a[30:0] < operand_b[30:0]);
  assign vec = {lt ? operand_a : operand_b, lt ? operand_b : operand_a, eq, lt, lt | eq};
  generate
    if (LATENCY == 0) begin : g_comb
      assign out = vec;
    end else begin : g_pipe
      logic [66:0] pipe [LATENCY];
      always_ff @(posedge clk_i) begin
        pipe[0] <= vec;
        for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
      end
      assign out = pipe[LATENCY-1];
    end
  endgenerate
  assign {min, max, equal, less, less_equal} = out;
endmodule

// File: rtl/fcmp_classify.sv
// fcmp_classify: single-precision operand classifier
//   val: IEEE-754 single; is_nan/is_snan/is_zero/sign: classification of val
module fcmp_classify
  import fcmp_pkg::*;
(
  input  logic [31:0] val,
  output logic        is_nan,
  output logic        is_snan,
  output logic        is_zero,
  output logic        sign
);
  assign is_nan  = (val[30:23] == EXP_ALL1) && (|val[22:0]);
  assign is_snan = is_nan && !val[22];
  assign is_zero = ~|val[30:0];
  assign sign    = val[31];
endmodule

// File: rtl/fcmp_ctrl.sv
// fcmp_ctrl: one-outstanding request/response wrapper around fcmp with RISC-V NaN/signed-zero fix-up
//   clk_i: clock; rst_ni: async active-low reset
//   bus: slave side of fcmp_ctrl_if (request in, response out)
module fcmp_ctrl
  import fcmp_pkg::*;
#(
  parameter int CMP_LATENCY = 1,
  parameter int TAG_W       = 4
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  fcmp_ctrl_if.slave bus
);
  fcmp_state_e      state;
  logic [2:0]       op, cnt;
  logic [31:0]      a, b;
  logic [TAG_W-1:0] tag;
  logic             req_ready, rsp_valid, rsp_nv;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      f_min, f_max, res;
  logic             f_eq, f_lt, f_le, nv;
  logic             na, nb, sna, snb, za, zb, sa, sb;
  fcmp #(.LATENCY(CMP_LATENCY)) u_fcmp (
    .clk_i(clk_i), .operand_a(a), .operand_b(b),
    .min(f_min), .max(f_max), .equal(f_eq), .less(f_lt), .less_equal(f_le)
  );
  fcmp_classify u_cls_a (.val(a), .is_nan(na), .is_snan(sna), .is_zero(za), .sign(sa));
  fcmp_classify u_cls_b (.val(b), .is_nan(nb), .is_snan(snb), .is_zero(zb), .sign(sb));
  always_comb begin
    res = '0;
    nv  = 1'b0;
    case (op)
      OP_MIN, OP_MAX: begin
        res = (na && nb) ? CANON_NAN
            : na ? b
            : nb ? a
            : (za && zb && (sa != sb)) ? ((op == OP_MIN) ? NEG_ZERO : 32'h0)
            : (op == OP_MIN) ? f_min : f_max;
        nv  = sna || snb;
      end
      OP_EQ: begin
        res = (na || nb) ? 32'h0 : {31'b0, f_eq};
        nv  = sna || snb;
      end
      OP_LT, OP_LE: begin
        res = (na || nb) ? 32'h0 : {31'b0, (op == OP_LT) ? f_lt : f_le};
        nv  = na || nb;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= IDLE;
      op         <= '0;
      a          <= '0;
      b          <= '0;
      tag        <= '0;
      cnt        <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_nv     <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          op        <= bus.req_op;
          a         <= bus.req_a;
          b         <= bus.req_b;
          tag       <= bus.req_tag;
          cnt       <= 3'(CMP_LATENCY);
          req_ready <= 1'b0;
          state     <= WAIT;
        end
        WAIT: if (cnt == 3'd0) begin
          rsp_result <= res;
          rsp_nv     <= nv;
          rsp_tag    <= tag;
          rsp_valid  <= 1'b1;
          state      <= HOLD;
        end else cnt <= cnt - 3'd1;
        HOLD: if (bus.rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_nv     = rsp_nv;
  assign bus.rsp_tag    = rsp_tag;
endmodule

// File: tb/tb_fcmp_ctrl.sv
// tb_fcmp_ctrl: directed self-checking bench for fcmp_ctrl with CMP_LATENCY=1
module tb_fcmp_ctrl;
  import fcmp_pkg::*;
  localparam int LAT = 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  fcmp_ctrl_if #(.TAG_W(4)) bus ();
  fcmp_ctrl #(.CMP_LATENCY(LAT), .TAG_W(4)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    @(negedge clk);
    chk("req_ready_idle", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic wait_rsp();
    int n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(LAT + 1));
    chk("req_ready_hold", {31'b0, bus.req_ready}, 32'd0);
  endtask
  task automatic chk_rsp(input string name, input logic [31:0] er, input logic env, input logic [3:0] etag);
    chk({name, "_result"}, bus.rsp_result, er);
    chk({name, "_nv"}, {31'b0, bus.rsp_nv}, {31'b0, env});
    chk({name, "_tag"}, {28'b0, bus.rsp_tag}, {28'b0, etag});
  endtask
  task automatic ack();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_clr", {31'b0, bus.rsp_valid}, 32'd0);
    chk("req_ready_back", {31'b0, bus.req_ready}, 32'd1);
  endtask
  task automatic txn(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] tag, input logic [31:0] er, input logic env);
    issue(op, a, b, tag);
    chk({name, "_not_early"}, {31'b0, bus.rsp_valid}, 32'd0);
    wait_rsp();
    chk_rsp(name, er, env, tag);
    ack();
  endtask
  task automatic chk_reset_vals(input string name);
    chk({name, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    chk({name, "_rsp_valid"}, {31'b0, bus.rsp_valid}, 32'd0);
    chk({name, "_result"}, bus.rsp_result, 32'd0);
    chk({name, "_nv"}, {31'b0, bus.rsp_nv}, 32'd0);
    chk({name, "_tag"}, {28'b0, bus.rsp_tag}, 32'd0);
  endtask
  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    txn("lt_1_2",        OP_LT,  32'h3F800000, 32'h40000000, 4'h5, 32'h1,        1'b0);
    txn("max_qnan",      OP_MAX, 32'h7FC00000, 32'hC0400000, 4'h6, 32'hC0400000, 1'b0);
    txn("max_snan",      OP_MAX, 32'h7F800001, 32'hC0400000, 4'h7, 32'hC0400000, 1'b1);
    txn("min_pz_nz",     OP_MIN, 32'h00000000, 32'h80000000, 4'h1, 32'h80000000, 1'b0);
    txn("max_pz_nz",     OP_MAX, 32'h00000000, 32'h80000000, 4'h2, 32'h00000000, 1'b0);
    txn("le_qnan",       OP_LE,  32'h7FC00000, 32'h3F800000, 4'h3, 32'h0,        1'b1);
    txn("eq_qnan",       OP_EQ,  32'h7FC00000, 32'h3F800000, 4'h4, 32'h0,        1'b0);
    txn("min_both_nan",  OP_MIN, 32'h7FC00000, 32'h7F800001, 4'h8, 32'h7FC00000, 1'b1);
    txn("lt_neg",        OP_LT,  32'hBF800000, 32'hC0000000, 4'hB, 32'h0,        1'b0);
    txn("op6",           3'd6,   32'h3F800000, 32'h40000000, 4'hD, 32'h0,        1'b0);
    // back-pressure: response held 5 cycles while a second request waits upstream
    issue(OP_MIN, 32'h3F800000, 32'hC0000000, 4'h9);
    wait_rsp();
    bus.req_valid = 1'b1;
    bus.req_op    = OP_EQ;
    bus.req_a     = 32'h40000000;
    bus.req_b     = 32'h40000000;
    bus.req_tag   = 4'hA;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_rsp("bp_hold", 32'hC0000000, 1'b0, 4'h9);
      chk("bp_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("bp_req_ready", {31'b0, bus.req_ready}, 32'd0);
    end
    ack();
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("bp_second_taken", {31'b0, bus.req_ready}, 32'd0);
    wait_rsp();
    chk_rsp("bp_second", 32'h1, 1'b0, 4'hA);
    ack();
    // async reset during WAIT drops the in-flight request
    issue(OP_LE, 32'hBF800000, 32'hC0000000, 4'h3);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("no_ghost_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    end
    txn("after_reset_le", OP_LE, 32'hBF800000, 32'hBF800000, 4'hC, 32'h1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
